// File: rtl/note_recorder.sv
// -----------------------------------------------------------------------------
// note_recorder
//
// Record/playback sequencer for the keyboard. While recording, the live note
// code is captured as (note, duration) events in an internal RAM. Durations are
// counted in ticks of a TICK_DIV-cycle prescaler. On playback the events are
// streamed back on nota_grabada, each held for exactly dur*TICK_DIV cycles and
// with no gap between events.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high; clears all state (RAM excluded)
//   nota_actual     live note code 0..65 (values above 65 are treated as 0)
//   btn_grabar      1-cycle pulse: start recording
//   btn_reproducir  1-cycle pulse: start playback
//   btn_parar       1-cycle pulse: stop recording/playback
//   nota_grabada    played-back note code, 0 when not playing
//   grabando        high while recording
//   reproduciendo   high while playing
//   lleno           RAM full after the last recording
//   nro_eventos     number of events stored by the last recording
// -----------------------------------------------------------------------------
module note_recorder #(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        nota_actual,
    input  logic              btn_grabar,
    input  logic              btn_reproducir,
    input  logic              btn_parar,
    output logic [7:0]        nota_grabada,
    output logic              grabando,
    output logic              reproduciendo,
    output logic              lleno,
    output logic [ADDR_W:0]   nro_eventos
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]   DUR_MAX    = {DUR_W{1'b1}};
    localparam logic [DUR_W-1:0]   DUR_ONE    = DUR_W'(1);
    localparam logic [ADDR_W:0]    DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_PLAY,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [7:0]          open_note_q, open_note_d;
    logic [DUR_W-1:0]    open_dur_q, open_dur_d;
    logic [ADDR_W:0]     nro_q, nro_d;
    logic                lleno_q, lleno_d;
    logic [7:0]          nota_q, nota_d;
    logic                grab_q, grab_d;
    logic                repro_q, repro_d;
    logic                loaded_q, loaded_d;
    logic [ADDR_W-1:0]   fetch_idx_q, fetch_idx_d;
    logic [ADDR_W:0]     left_q, left_d;
    logic [DUR_W-1:0]    dur_left_q, dur_left_d;

    logic [7:0]          note_in;
    logic                tick;
    logic [ADDR_W:0]     nro_inc;
    logic [DUR_W-1:0]    open_dur_inc;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DUR_W+7:0]    wr_data;
    logic [DUR_W+7:0]    ram_rd_q;
    logic [7:0]          rd_note;
    logic [DUR_W-1:0]    rd_dur;

    // Event RAM: {note, dur} per slot, registered read.
    logic [DUR_W+7:0]    mem [DEPTH];

    assign note_in      = (nota_actual > 8'd65) ? 8'd0 : nota_actual;
    assign tick         = (presc_q == PRESC_LAST);
    assign nro_inc      = nro_q + 1'b1;
    assign open_dur_inc = open_dur_q + 1'b1;
    assign wr_addr      = nro_q[ADDR_W-1:0];
    assign rd_note      = ram_rd_q[DUR_W +: 8];
    assign rd_dur       = ram_rd_q[DUR_W-1:0];

    // The read address is the next-state fetch index, so ram_rd_q always
    // holds the entry at fetch_idx_q: the next event is ready (prefetched)
    // by the time the current one finishes, even for one-cycle events.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        ram_rd_q <= mem[fetch_idx_d];
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        open_note_d = open_note_q;
        open_dur_d  = open_dur_q;
        nro_d       = nro_q;
        lleno_d     = lleno_q;
        nota_d      = nota_q;
        grab_d      = grab_q;
        repro_d     = repro_q;
        loaded_d    = loaded_q;
        fetch_idx_d = fetch_idx_q;
        left_d      = left_q;
        dur_left_d  = dur_left_q;
        wr_en       = 1'b0;
        wr_data     = {open_note_q, open_dur_q};

        case (state_q)
            S_IDLE: begin
                fetch_idx_d = '0;
                if (btn_parar) begin
                    state_d = S_IDLE;
                end else if (btn_grabar) begin
                    state_d     = S_REC;
                    grab_d      = 1'b1;
                    nro_d       = '0;
                    lleno_d     = 1'b0;
                    open_note_d = note_in;
                    open_dur_d  = DUR_ONE;
                    presc_d     = '0;
                end else if (btn_reproducir && (nro_q != '0)) begin
                    state_d  = S_PLAY;
                    repro_d  = 1'b1;
                    loaded_d = 1'b0;
                    left_d   = nro_q;
                    presc_d  = '0;
                end
            end

            S_REC: begin
                if (btn_parar) begin
                    state_d = S_FLUSH;
                    grab_d  = 1'b0;
                end else if (note_in != open_note_q) begin
                    // A note change closes the open event; a tick landing
                    // on the same cycle is not credited to either event.
                    wr_en       = 1'b1;
                    open_note_d = note_in;
                    open_dur_d  = DUR_ONE;
                end else if (tick) begin
                    if (open_dur_inc == DUR_MAX) begin
                        // Saturated: store it and keep the note going in a
                        // fresh event.
                        wr_en      = 1'b1;
                        wr_data    = {open_note_q, DUR_MAX};
                        open_dur_d = DUR_ONE;
                    end else begin
                        open_dur_d = open_dur_inc;
                    end
                end
            end

            S_FLUSH: begin
                wr_en   = !lleno_q;
                state_d = S_IDLE;
                grab_d  = 1'b0;
            end

            S_PLAY: begin
                if (btn_parar) begin
                    state_d = S_IDLE;
                    nota_d  = 8'd0;
                    repro_d = 1'b0;
                end else if (!loaded_q || (tick && (dur_left_q == DUR_ONE))) begin
                    // Event boundary (or the very first load after entry).
                    presc_d = '0;
                    if (left_q == '0) begin
                        state_d = S_IDLE;
                        nota_d  = 8'd0;
                        repro_d = 1'b0;
                    end else begin
                        nota_d      = rd_note;
                        dur_left_d  = rd_dur;
                        left_d      = left_q - 1'b1;
                        fetch_idx_d = fetch_idx_q + 1'b1;
                        loaded_d    = 1'b1;
                    end
                end else if (tick) begin
                    dur_left_d = dur_left_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common bookkeeping for any RAM write from REC or FLUSH.
        if (wr_en) begin
            nro_d = nro_inc;
            if (nro_inc == DEPTH_CNT) begin
                lleno_d = 1'b1;
                state_d = S_IDLE;
                grab_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            open_note_q <= '0;
            open_dur_q  <= '0;
            nro_q       <= '0;
            lleno_q     <= 1'b0;
            nota_q      <= '0;
            grab_q      <= 1'b0;
            repro_q     <= 1'b0;
            loaded_q    <= 1'b0;
            fetch_idx_q <= '0;
            left_q      <= '0;
            dur_left_q  <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            open_note_q <= open_note_d;
            open_dur_q  <= open_dur_d;
            nro_q       <= nro_d;
            lleno_q     <= lleno_d;
            nota_q      <= nota_d;
            grab_q      <= grab_d;
            repro_q     <= repro_d;
            loaded_q    <= loaded_d;
            fetch_idx_q <= fetch_idx_d;
            left_q      <= left_d;
            dur_left_q  <= dur_left_d;
        end
    end

    assign nota_grabada  = nota_q;
    assign grabando      = grab_q;
    assign reproduciendo = repro_q;
    assign lleno         = lleno_q;
    assign nro_eventos   = nro_q;

endmodule

// File: tb/tb_note_recorder.sv
// -----------------------------------------------------------------------------
// tb_note_recorder
//
// Bench for note_recorder with a small configuration (DEPTH=4, DUR_W=4,
// TICK_DIV=4). Recordings are described in a table; each one is recorded,
// its stored state checked, and then played back while a scoreboard queue
// of per-cycle expected outputs is drained and compared by a monitor on the
// falling edge. Overflow, saturation, priority/abort and async reset are
// driven as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_note_recorder;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] nota_actual;
    logic       btn_grabar;
    logic       btn_reproducir;
    logic       btn_parar;
    logic [7:0] nota_grabada;
    logic       grabando;
    logic       reproduciendo;
    logic       lleno;
    logic [2:0] nro_eventos;

    note_recorder #(
        .DEPTH   (4),
        .ADDR_W  (2),
        .DUR_W   (4),
        .TICK_DIV(TD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .nota_actual   (nota_actual),
        .btn_grabar    (btn_grabar),
        .btn_reproducir(btn_reproducir),
        .btn_parar     (btn_parar),
        .nota_grabada  (nota_grabada),
        .grabando      (grabando),
        .reproduciendo (reproduciendo),
        .lleno         (lleno),
        .nro_eventos   (nro_eventos)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] nota;
        logic       repro;
        logic       grab;
    } samp_t;

    typedef struct {
        logic [7:0] note;
        int         dur;
    } ev_t;

    typedef struct {
        logic [7:0] n0;
        int         c0;
        logic [7:0] n1;
        int         c1;
        int         nro;
        logic [7:0] e0n;
        int         e0d;
        logic [7:0] e1n;
        int         e1d;
    } vec_t;

    samp_t sb_q[$];
    ev_t   ev_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    samp_t mon_exp;
    samp_t mon_act;

    // Scoreboard monitor: one expected sample per cycle while entries exist.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_act.nota  = nota_grabada;
            mon_act.repro = reproduciendo;
            mon_act.grab  = grabando;
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL play_stream t=%0t: got nota=%0d repro=%0b grab=%0b, expected nota=%0d repro=%0b grab=%0b",
                         $time, mon_act.nota, mon_act.repro, mon_act.grab,
                         mon_exp.nota, mon_exp.repro, mon_exp.grab);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] nota, input logic repro, input int count);
        samp_t s;
        s.nota  = nota;
        s.repro = repro;
        s.grab  = 1'b0;
        for (int i = 0; i < count; i++) sb_q.push_back(s);
    endtask

    // Grabar with n0, hold n0 for c0 cycles, then n1 for c1 cycles, parar,
    // and wait until the flushed event is visible in nro_eventos.
    task automatic record(input logic [7:0] n0, input int c0, input logic [7:0] n1, input int c1);
        nota_actual = n0;
        btn_grabar  = 1'b1;
        cyc();
        btn_grabar  = 1'b0;
        for (int i = 0; i < c0; i++) cyc();
        nota_actual = n1;
        for (int i = 0; i < c1; i++) cyc();
        btn_parar = 1'b1;
        cyc();
        btn_parar = 1'b0;
        cyc();
    endtask

    // Play back and expect the events in ev_q; a grabar pulse mid-play
    // must be ignored.
    task automatic play_and_check(input string name);
        btn_reproducir = 1'b1;
        push(8'd0, 1'b0, 1);                  // press cycle: still idle
        push(8'd0, 1'b1, 1);                  // RAM latency cycle
        foreach (ev_q[i]) push(ev_q[i].note, 1'b1, ev_q[i].dur * TD);
        push(8'd0, 1'b0, 1);                  // end: silence and idle together
        cyc();
        btn_reproducir = 1'b0;
        repeat (3) cyc();
        btn_grabar = 1'b1;
        cyc();
        btn_grabar = 1'b0;
        for (int i = 0; i < 3000 && sb_q.size() > 0; i++) cyc();
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d samples left, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'd14, 12, 8'd0,  8, 2, 8'd14, 4, 8'd0,  3};
        vecs[1] = '{8'd14,  8, 8'd27, 4, 2, 8'd14, 3, 8'd27, 2};
        vecs[2] = '{8'd200, 4, 8'd65, 4, 2, 8'd0,  2, 8'd65, 2};
        vecs[3] = '{8'd66,  4, 8'd0,  4, 1, 8'd0,  3, 8'd0,  0};
        vecs[4] = '{8'd7,   4, 8'd7,  4, 1, 8'd7,  3, 8'd0,  0};
        vecs[5] = '{8'd1,   3, 8'd2,  1, 2, 8'd1,  1, 8'd2,  1};

        reset          = 1'b1;
        nota_actual    = 8'd0;
        btn_grabar     = 1'b0;
        btn_reproducir = 1'b0;
        btn_parar      = 1'b0;
        #1;
        chk("reset_nota", nota_grabada, 0);
        chk("reset_grabando", grabando, 0);
        chk("reset_reproduciendo", reproduciendo, 0);
        chk("reset_lleno", lleno, 0);
        chk("reset_nro", nro_eventos, 0);
        cyc();
        cyc();
        reset = 1'b0;

        // Playback with nothing recorded is ignored.
        btn_reproducir = 1'b1;
        cyc();
        btn_reproducir = 1'b0;
        cyc();
        chk("empty_play_repro", reproduciendo, 0);

        // Table-driven recordings followed by playback.
        foreach (vecs[v]) begin
            record(vecs[v].n0, vecs[v].c0, vecs[v].n1, vecs[v].c1);
            chk($sformatf("vec%0d_nro", v), nro_eventos, vecs[v].nro);
            chk($sformatf("vec%0d_lleno", v), lleno, 0);
            chk($sformatf("vec%0d_grabando", v), grabando, 0);
            ev_q.delete();
            ev_q.push_back('{vecs[v].e0n, vecs[v].e0d});
            if (vecs[v].nro > 1) ev_q.push_back('{vecs[v].e1n, vecs[v].e1d});
            play_and_check($sformatf("vec%0d_play", v));
            chk($sformatf("vec%0d_nro_after_play", v), nro_eventos, vecs[v].nro);
        end

        // Overflow: note k on cycles 2k-1 and 2k after grabar.
        nota_actual = 8'd1;
        btn_grabar  = 1'b1;
        cyc();
        btn_grabar  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin
                chk("ovf_nro_before_full", nro_eventos, 3);
                chk("ovf_grabando_before_full", grabando, 1);
            end
            nota_actual = 8'(k);
            cyc();
            cyc();
        end
        chk("ovf_nro", nro_eventos, 4);
        chk("ovf_lleno", lleno, 1);
        chk("ovf_grabando", grabando, 0);
        ev_q.delete();
        ev_q.push_back('{8'd1, 1});
        ev_q.push_back('{8'd2, 2});
        ev_q.push_back('{8'd3, 1});
        ev_q.push_back('{8'd4, 2});
        play_and_check("ovf_play");
        chk("ovf_lleno_after_play", lleno, 1);
        chk("ovf_nro_after_play", nro_eventos, 4);

        // Saturation: 17 ticks of one note -> (5,15) then (5,4).
        record(8'd5, 70, 8'd5, 0);
        chk("sat_nro", nro_eventos, 2);
        chk("sat_lleno", lleno, 0);
        ev_q.delete();
        ev_q.push_back('{8'd5, 15});
        ev_q.push_back('{8'd5, 4});
        play_and_check("sat_play");

        // parar beats reproducir in IDLE.
        btn_parar      = 1'b1;
        btn_reproducir = 1'b1;
        cyc();
        btn_parar      = 1'b0;
        btn_reproducir = 1'b0;
        chk("prio_parar_repro", reproduciendo, 0);
        cyc();
        chk("prio_parar_nota", nota_grabada, 0);

        // grabar beats reproducir in IDLE.
        nota_actual    = 8'd9;
        btn_grabar     = 1'b1;
        btn_reproducir = 1'b1;
        cyc();
        btn_grabar     = 1'b0;
        btn_reproducir = 1'b0;
        chk("prio_grab_grabando", grabando, 1);
        chk("prio_grab_repro", reproduciendo, 0);
        btn_parar = 1'b1;
        cyc();
        btn_parar = 1'b0;
        cyc();
        chk("prio_grab_nro", nro_eventos, 1);

        // Abort mid-play: (9,1) would still be sounding.
        btn_reproducir = 1'b1;
        cyc();
        btn_reproducir = 1'b0;
        cyc();
        cyc();
        chk("abort_nota_playing", nota_grabada, 9);
        btn_parar = 1'b1;
        cyc();
        btn_parar = 1'b0;
        chk("abort_nota", nota_grabada, 0);
        chk("abort_repro", reproduciendo, 0);

        // Async reset mid-play, away from any clock edge.
        btn_reproducir = 1'b1;
        cyc();
        btn_reproducir = 1'b0;
        cyc();
        chk("areset_nota_playing", nota_grabada, 9);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_nota", nota_grabada, 0);
        chk("areset_repro", reproduciendo, 0);
        chk("areset_nro", nro_eventos, 0);
        chk("areset_lleno", lleno, 0);
        chk("areset_grabando", grabando, 0);
        #1;
        reset = 1'b0;
        cyc();
        btn_reproducir = 1'b1;
        cyc();
        btn_reproducir = 1'b0;
        cyc();
        chk("areset_play_ignored", reproduciendo, 0);
        chk("areset_play_nota", nota_grabada, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
